// File: rtl/tx_word_scheduler.sv
// tx_word_scheduler
//   Two requesters each hand over 16-bit words through a one-deep holding
//   register. A round-robin arbiter picks a pending word and serializes it
//   as two bytes to a ready/valid byte sink. A word's two bytes are always
//   sent back to back, and at least one idle cycle follows each word.
//
// Ports
//   clk                     system clock, rising edge
//   rst                     asynchronous reset, active low
//   ce                      clock enable; no state changes while low
//   req0_dv / req1_dv       single-cycle word strobes
//   req0_word / req1_word   16-bit words
//   req0_busy / req1_busy   holding register occupied
//   tx_ready                sink accepts the byte on byte_data this edge
//   byte_dv                 byte_data valid
//   byte_data               byte to sink ("byte" is a reserved word in SV)
//   grant                   requester that owns the word on byte_data
//   ovf                     sticky overflow flags, bit n = requester n
//
// FSM states
//   state  | meaning
//   IDLE   | no word in flight; selects a pending word if any
//   SEND_A | first byte on byte_data, waiting for tx_ready
//   SEND_B | second byte on byte_data, waiting for tx_ready
module tx_word_scheduler #(
  parameter bit HI_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        req0_dv,
  input  logic [15:0] req0_word,
  output logic        req0_busy,
  input  logic        req1_dv,
  input  logic [15:0] req1_word,
  output logic        req1_busy,
  input  logic        tx_ready,
  output logic        byte_dv,
  output logic [7:0]  byte_data,
  output logic        grant,
  output logic [1:0]  ovf
);

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;

  state_t      state_q, state_d;
  logic        pend0_q, pend0_d;
  logic        pend1_q, pend1_d;
  logic [1:0]  ovf_q, ovf_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [15:0] hold0_q, hold0_d;
  logic [15:0] hold1_q, hold1_d;
  logic [15:0] shift_q, shift_d;

  logic        take;
  logic        sel;

  // State register and control flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      ovf_q   <= 2'b00;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else if (ce) begin
      state_q <= state_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      ovf_q   <= ovf_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Data registers carry no meaning after reset, so they skip the reset net
  always_ff @(posedge clk) begin
    if (ce) begin
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic and datapath updates
  always_comb begin
    // On a tie the requester not served last wins; otherwise whoever is pending
    sel     = (pend0_q && pend1_q) ? ~last_q : pend1_q;
    take    = (state_q == IDLE) && (pend0_q || pend1_q);

    state_d = state_q;
    case (state_q)
      IDLE:    if (pend0_q || pend1_q) state_d = SEND_A;
      SEND_A:  if (tx_ready)           state_d = SEND_B;
      SEND_B:  if (tx_ready)           state_d = IDLE;
      default:                         state_d = IDLE;
    endcase

    // A strobe while the slot is still full (including the edge that frees
    // it) is an overflow; the word is dropped.
    pend0_d = pend0_q;
    pend1_d = pend1_q;
    hold0_d = hold0_q;
    hold1_d = hold1_q;
    ovf_d   = ovf_q | {req1_dv & pend1_q, req0_dv & pend0_q};

    if (take && !sel) pend0_d = 1'b0;
    if (take &&  sel) pend1_d = 1'b0;
    if (req0_dv && !pend0_q) begin
      pend0_d = 1'b1;
      hold0_d = req0_word;
    end
    if (req1_dv && !pend1_q) begin
      pend1_d = 1'b1;
      hold1_d = req1_word;
    end

    shift_d = shift_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (take) begin
      shift_d = sel ? hold1_q : hold0_q;
      grant_d = sel;
      last_d  = sel;
    end
  end

  // Outputs decode directly from registered state, so they stay stable
  // through stalls and while ce is low.
  always_comb begin
    byte_dv   = 1'b0;
    byte_data = 8'h00;
    case (state_q)
      SEND_A: begin
        byte_dv   = 1'b1;
        byte_data = HI_FIRST ? shift_q[15:8] : shift_q[7:0];
      end
      SEND_B: begin
        byte_dv   = 1'b1;
        byte_data = HI_FIRST ? shift_q[7:0] : shift_q[15:8];
      end
      default: begin
        byte_dv   = 1'b0;
        byte_data = 8'h00;
      end
    endcase
    grant     = grant_q;
    ovf       = ovf_q;
    req0_busy = pend0_q;
    req1_busy = pend1_q;
  end

endmodule

// File: tb/tb_tx_word_scheduler.sv
module tb_tx_word_scheduler;

  logic        clk = 1'b0;
  logic        rst, ce, tx_ready;
  logic        req0_dv, req1_dv;
  logic [15:0] req0_word, req1_word;
  logic        req0_busy, req1_busy, byte_dv, grant;
  logic [7:0]  byte_data;
  logic [1:0]  ovf;

  logic        h_req0_dv, h_req1_dv;
  logic [15:0] h_req0_word, h_req1_word;
  logic        h_req0_busy, h_req1_busy, h_byte_dv, h_grant;
  logic [7:0]  h_byte;
  logic [1:0]  h_ovf;

  int checks = 0;
  int errors = 0;

  logic [8:0] q_lo[$];
  logic [8:0] q_hi[$];
  logic [8:0] m_exp;

  always #5 clk = ~clk;

  tx_word_scheduler #(.HI_FIRST(1'b0)) u_lo (
    .clk(clk), .rst(rst), .ce(ce),
    .req0_dv(req0_dv), .req0_word(req0_word), .req0_busy(req0_busy),
    .req1_dv(req1_dv), .req1_word(req1_word), .req1_busy(req1_busy),
    .tx_ready(tx_ready), .byte_dv(byte_dv), .byte_data(byte_data),
    .grant(grant), .ovf(ovf)
  );

  tx_word_scheduler #(.HI_FIRST(1'b1)) u_hi (
    .clk(clk), .rst(rst), .ce(ce),
    .req0_dv(h_req0_dv), .req0_word(h_req0_word), .req0_busy(h_req0_busy),
    .req1_dv(h_req1_dv), .req1_word(h_req1_word), .req1_busy(h_req1_busy),
    .tx_ready(tx_ready), .byte_dv(h_byte_dv), .byte_data(h_byte),
    .grant(h_grant), .ovf(h_ovf)
  );

  // Monitor: every byte the sink accepts must match the next expected entry
  always @(negedge clk) begin
    if (rst && ce && byte_dv && tx_ready) begin
      checks++;
      if (q_lo.size() == 0) begin
        errors++;
        $display("FAIL lo_unexpected_byte actual=%h grant=%0d required=none", byte_data, grant);
      end else begin
        m_exp = q_lo.pop_front();
        if ({grant, byte_data} !== m_exp) begin
          errors++;
          $display("FAIL lo_byte actual=%0d/%h required=%0d/%h", grant, byte_data, m_exp[8], m_exp[7:0]);
        end
      end
    end
    if (rst && ce && h_byte_dv && tx_ready) begin
      checks++;
      if (q_hi.size() == 0) begin
        errors++;
        $display("FAIL hi_unexpected_byte actual=%h grant=%0d required=none", h_byte, h_grant);
      end else begin
        m_exp = q_hi.pop_front();
        if ({h_grant, h_byte} !== m_exp) begin
          errors++;
          $display("FAIL hi_byte actual=%0d/%h required=%0d/%h", h_grant, h_byte, m_exp[8], m_exp[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q_lo.size() != 0 || q_hi.size() != 0); i++) step();
    check("drain_lo_empty", 32'(q_lo.size()), 32'd0);
    check("drain_hi_empty", 32'(q_hi.size()), 32'd0);
    q_lo.delete();
    q_hi.delete();
    step();
  endtask

  logic [15:0] rr_w0 [2] = '{16'h0A0B, 16'h2E2F};
  logic [15:0] rr_w1 [2] = '{16'h1C1D, 16'h3031};

  initial begin
    rst = 1'b0; ce = 1'b1; tx_ready = 1'b1;
    req0_dv = 1'b0; req1_dv = 1'b0; req0_word = '0; req1_word = '0;
    h_req0_dv = 1'b0; h_req1_dv = 1'b0; h_req0_word = '0; h_req1_word = '0;
    repeat (2) step();

    check("rst_byte_dv", 32'(byte_dv),   32'd0);
    check("rst_byte",    32'(byte_data), 32'h00);
    check("rst_grant",   32'(grant),     32'd0);
    check("rst_ovf",     32'(ovf),       32'd0);
    check("rst_busy0",   32'(req0_busy), 32'd0);
    check("rst_busy1",   32'(req1_busy), 32'd0);
    rst = 1'b1;
    step();

    // Single word, low byte first, with cycle-exact timing
    q_lo.push_back({1'b0, 8'h5A});
    q_lo.push_back({1'b0, 8'hA5});
    req0_word = 16'hA55A; req0_dv = 1'b1;
    step();
    req0_dv = 1'b0;
    check("a55a_busy0", 32'(req0_busy), 32'd1);
    step();
    check("a55a_first_dv",   32'(byte_dv),   32'd1);
    check("a55a_first_byte", 32'(byte_data), 32'h5A);
    check("a55a_grant",      32'(grant),     32'd0);
    step();
    check("a55a_second_byte", 32'(byte_data), 32'hA5);
    step();
    check("a55a_gap_dv",   32'(byte_dv),   32'd0);
    check("a55a_gap_byte", 32'(byte_data), 32'h00);
    drain();

    // High byte first
    q_hi.push_back({1'b0, 8'h12});
    q_hi.push_back({1'b0, 8'h34});
    h_req0_word = 16'h1234; h_req0_dv = 1'b1;
    step();
    h_req0_dv = 1'b0;
    step();
    check("hi_first_byte", 32'(h_byte), 32'h12);
    step();
    check("hi_second_byte", 32'(h_byte), 32'h34);
    drain();

    // Tie from reset: requester 0 wins first
    do_reset();
    q_lo.push_back({1'b0, 8'h11}); q_lo.push_back({1'b0, 8'h11});
    q_lo.push_back({1'b1, 8'h22}); q_lo.push_back({1'b1, 8'h22});
    req0_word = 16'h1111; req1_word = 16'h2222;
    req0_dv = 1'b1; req1_dv = 1'b1;
    step();
    req0_dv = 1'b0; req1_dv = 1'b0;
    drain();

    // Repeated refill of both: grants alternate 0,1,0,1
    for (int r = 0; r < 2; r++) begin
      q_lo.push_back({1'b0, rr_w0[r][7:0]}); q_lo.push_back({1'b0, rr_w0[r][15:8]});
      q_lo.push_back({1'b1, rr_w1[r][7:0]}); q_lo.push_back({1'b1, rr_w1[r][15:8]});
      req0_word = rr_w0[r]; req1_word = rr_w1[r];
      req0_dv = 1'b1; req1_dv = 1'b1;
      step();
      req0_dv = 1'b0; req1_dv = 1'b0;
      drain();
    end

    // Stall in SEND_A
    tx_ready = 1'b0;
    q_lo.push_back({1'b0, 8'hEF});
    q_lo.push_back({1'b0, 8'hBE});
    req0_word = 16'hBEEF; req0_dv = 1'b1;
    step();
    req0_dv = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_dv",    32'(byte_dv),   32'd1);
      check("stall_byte",  32'(byte_data), 32'hEF);
      check("stall_grant", 32'(grant),     32'd0);
      step();
    end
    tx_ready = 1'b1;
    drain();

    // Overflow on requester 1 while its slot is full
    tx_ready = 1'b0;
    q_lo.push_back({1'b0, 8'h02}); q_lo.push_back({1'b0, 8'h01});
    q_lo.push_back({1'b1, 8'h04}); q_lo.push_back({1'b1, 8'h03});
    req0_word = 16'h0102; req0_dv = 1'b1;
    step();
    req0_dv = 1'b0;
    req1_word = 16'h0304; req1_dv = 1'b1;
    step();
    req1_word = 16'h0506;
    step();
    req1_word = 16'h0708;
    step();
    req1_dv = 1'b0;
    check("ovf_flags", 32'(ovf),       32'h2);
    check("ovf_busy1", 32'(req1_busy), 32'd1);
    check("ovf_busy0", 32'(req0_busy), 32'd0);
    tx_ready = 1'b1;
    drain();
    check("ovf_sticky", 32'(ovf), 32'h2);

    // Reset during SEND_B aborts the word
    q_lo.push_back({1'b0, 8'hFE});
    req0_word = 16'hCAFE; req0_dv = 1'b1;
    step();
    req0_dv = 1'b0;
    step();
    step();
    check("abort_pre_byte", 32'(byte_data), 32'hCA);
    rst = 1'b0;
    #1;
    check("abort_dv",   32'(byte_dv),   32'd0);
    check("abort_byte", 32'(byte_data), 32'h00);
    check("abort_ovf",  32'(ovf),       32'd0);
    step();
    step();
    rst = 1'b1;
    check("abort_q_empty", 32'(q_lo.size()), 32'd0);
    q_lo.push_back({1'b0, 8'h21});
    q_lo.push_back({1'b0, 8'h43});
    req0_word = 16'h4321; req0_dv = 1'b1;
    step();
    req0_dv = 1'b0;
    drain();

    // ce low with pending words freezes everything
    q_lo.push_back({1'b1, 8'h88}); q_lo.push_back({1'b1, 8'h77});
    q_lo.push_back({1'b0, 8'h66}); q_lo.push_back({1'b0, 8'h55});
    req0_word = 16'h5566; req1_word = 16'h7788;
    req0_dv = 1'b1; req1_dv = 1'b1;
    step();
    req1_dv = 1'b0;
    ce = 1'b0;
    req0_word = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      check("ce_dv",    32'(byte_dv),   32'd0);
      check("ce_busy0", 32'(req0_busy), 32'd1);
      check("ce_busy1", 32'(req1_busy), 32'd1);
      check("ce_ovf",   32'(ovf),       32'd0);
      step();
    end
    req0_dv = 1'b0;
    ce = 1'b1;
    step();
    check("ce_resume_dv",    32'(byte_dv),   32'd1);
    check("ce_resume_grant", 32'(grant),     32'd1);
    check("ce_resume_byte",  32'(byte_data), 32'h88);
    drain();

    repeat (5) step();
    check("final_lo_empty", 32'(q_lo.size()), 32'd0);
    check("final_ovf",      32'(ovf),         32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_word_scheduler.md
TX_WORD_SCHEDULER -- requirements
Module: tx_word_scheduler

Interface
REQ-001 SHALL have parameter HI_FIRST, default 0; 0 = low byte sent first, 1 = high byte sent first.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ce  input  1  clock enable; no state changes when low.
REQ-005 SHALL have port req0_dv  input  1  requester 0 word valid (single-cycle strobe).
REQ-006 SHALL have port req0_word  input  16  requester 0 word.
REQ-007 SHALL have port req0_busy  output  1  requester 0 holding slot occupied.
REQ-008 SHALL have ports req1_dv, req1_word and req1_busy, identical to the requester 0 ports, for requester 1.
REQ-009 SHALL have port tx_ready  input  1  downstream byte sink can accept a byte.
REQ-010 SHALL have port byte_dv  output  1  byte valid to sink.
REQ-011 SHALL have port byte  output  8  byte to sink.
REQ-012 SHALL have port grant  output  1  index of requester whose word is on byte; valid while byte_dv high.
REQ-013 SHALL have port ovf  output  2  sticky per-requester overflow flags; bit n = requester n.

Function
REQ-014 SHALL hold one 16-bit word per requester in a holding register with a pend flag; reqN_busy = pendN.
REQ-015 SHALL capture reqN_word and set pendN at a ce edge where reqN_dv=1 and pendN=0.
REQ-016 SHALL discard the word and set ovf[n] at a ce edge where reqN_dv=1 and pendN=1; ovf bits clear only on reset.
REQ-017 SHALL implement an FSM with states IDLE, SEND_A and SEND_B.
REQ-018 In IDLE with any pend set, at the next ce edge the FSM SHALL select a requester, copy its word into the shift register, clear its pend flag, latch grant, and enter SEND_A.
REQ-019 Arbitration SHALL be round-robin: with both pend flags set, select the requester not selected last; with one set, select that one.
REQ-020 The last-selected register SHALL reset to 1, so requester 0 wins the first tie.
REQ-021 In SEND_A, byte SHALL equal word[7:0] (HI_FIRST=0) or word[15:8] (HI_FIRST=1), with byte_dv=1.
REQ-022 In SEND_B, byte SHALL carry the other half, with byte_dv=1.
REQ-023 The transfer SHALL complete only at a ce edge with byte_dv=1 and tx_ready=1.
REQ-024 While the transfer is stalled, byte, byte_dv and grant SHALL remain stable.
REQ-025 Transfer completion SHALL move SEND_A to SEND_B and SEND_B to IDLE, giving a one-cycle gap between words.
REQ-026 Outside SEND_A and SEND_B, byte_dv SHALL be 0 and byte SHALL be 8'h00.
REQ-027 Timing: word captured at edge N -> selected at edge N+1 -> first byte_dv high from edge N+1 to edge N+2 when tx_ready is held at 1.
REQ-028 A pend flag cleared at edge N SHALL allow a new capture from edge N+1; reqN_dv at edge N itself SHALL count as overflow.
REQ-029 Words from one requester SHALL never interleave bytes with words from the other requester.
REQ-030 With ce=0, the block SHALL ignore reqN_dv and tx_ready, and all outputs SHALL hold.

Reset
REQ-031 While rst=0, the block SHALL asynchronously force FSM=IDLE, pend0=pend1=0, ovf=2'b00, byte_dv=0, byte=8'h00, grant=0, and last-selected=1.
REQ-032 The block SHALL treat holding and shift register contents as don't-care after reset.
REQ-033 Reset asserted mid-word SHALL abort the transfer with no further bytes; the lost word is not resent.
REQ-034 The first ce edge after rst deasserts SHALL behave as normal operation.

Verification
REQ-035 The bench SHALL check this scenario: HI_FIRST=0, ce=1, tx_ready=1, req0 word 16'hA55A -> byte 8'h5A then 8'hA5 on consecutive cycles, grant=0, then byte_dv=0 for one cycle.
REQ-036 The bench SHALL check this scenario: same edge, req0 word 16'h1111 and req1 word 16'h2222 -> bytes 11,11 then 22,22, with grant 0 then 1.
REQ-037 The bench SHALL check this scenario: with both requesters then refilled repeatedly -> grant alternates 0,1,0,1.
REQ-038 The bench SHALL check this scenario: tx_ready=0 for 5 cycles during SEND_A of 16'hBEEF -> byte holds 8'hEF with byte_dv=1; after tx_ready=1, 8'hBE follows.
REQ-039 The bench SHALL check this scenario: req1_dv pulsed twice while pend1=1 -> ovf=2'b10, second word absent from output, req0 unaffected.
REQ-040 The bench SHALL check this scenario: HI_FIRST=1 with word 16'h1234 -> bytes 8'h12 then 8'h34.
REQ-041 The bench SHALL check this scenario: rst low during SEND_B -> byte_dv=0 immediately, ovf=0; after release, a new req0 word is serialized normally.
REQ-042 The bench SHALL check this scenario: ce held low for 3 cycles with pending words -> no output change; activity resumes when ce=1.
